mips_main_control: RTL and testbench
====================================

Name: mips_main_control

Overview:
Multicycle MIPS main control unit. It is the producer of the ALUOp/Funct interface consumed by the ALU control decoder. It sequences fetch, decode, execute, memory and writeback for the supported subset, and drives every datapath mux select and write strobe. It also handles overflow and invalid-opcode exceptions and halts on BREAK.

Parameters:
MEM_WAIT, 1, extra wait cycles per memory read/write access (0..7); an access holds for MEM_WAIT+1 cycles.
EXC_CNT_W, 3, width of the internal wait counter; must satisfy 2^EXC_CNT_W > MEM_WAIT.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
Opcode  in  6  IR[31:26], valid from DECODE onward
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag (combinational, current cycle)
Overflow  in  1  ALU signed overflow (combinational, current cycle)
Break  in  1  BREAK flag from ALU control (Funct==6'h0d)
ALUOp  out  3  000 add, 001 sub, 010 use Funct, 011 xor, 100 and
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
IorD  out  1  0=PC, 1=ALUOut as memory address
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load instruction register
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=exception vector
PCWrite  out  1  PC load (unconditional or resolved branch)
EPCWrite  out  1  load EPC from ALU result
CauseWrite  out  1  load Cause register
Cause  out  1  0=invalid opcode, 1=overflow
Halted  out  1  high in HALT

Behaviour:
- Reset sampled low at a rising edge: state <= RST, wait counter <= 0, IsBne <= 0. In RST all outputs are 0. RST lasts one cycle after reset is released, then the FSM enters FETCH.
- Reset low in any state aborts the instruction; no strobe is asserted from the following cycle.
- All outputs are Moore-decoded from the state, except PCWrite in BRANCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. The counter counts 0..MEM_WAIT. IRWrite=1 and PCWrite=1 only when counter==MEM_WAIT, then DECODE. Counter clears on every state exit.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). IsBne <= (Opcode==05).
  - Opcode 00: Break -> HALT, else RTYPE.
  - 23/2b -> MEM_ADDR.
  - 04/05 -> BRANCH.
  - 02 -> JUMP.
  - 08/09/0c/0e -> ITYPE.
  - Anything else -> EXC with Cause=0.
- RTYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=010. If Overflow and Funct is 20 or 22 -> EXC with Cause=1, else RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- ITYPE: ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for 08/09, 100 for 0c, 011 for 0e. If Overflow and Opcode==08 -> EXC with Cause=1, else IWB.
- IWB: RegDst=0, RegWrite=1, then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. 23 -> MEM_RD, 2b -> MEM_WR.
- MEM_RD: IorD=1, MemRead=1 for MEM_WAIT+1 cycles, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEM_WR: IorD=1, MemWrite=1 for MEM_WAIT+1 cycles, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = Zero XOR IsBne. Then FETCH.
- JUMP: PCSource=10, PCWrite=1, then FETCH.
- EXC: ALUSrcA=0, ALUSrcB=01, ALUOp=001 (PC-4 gives the faulting PC). EPCWrite=1, CauseWrite=1, Cause as latched, then EXC_VEC.
- EXC_VEC: PCSource=11, PCWrite=1, then FETCH.
- Cause is held in a register set on the transition into EXC.
- RegWrite is never asserted in a cycle that leads to EXC; the overflowing result is discarded.
- HALT: Halted=1, all strobes 0, held until reset.
- Unused or illegal state encodings go to RST on the next edge.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum state_t (RST, FETCH, DECODE, RTYPE, RWB, ITYPE, IWB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, EXC, EXC_VEC, HALT).
  - Opcode constants and Funct constants (ADD=20, SUB=22, BREAK=0d).
  - ALUOp constants ALUOP_ADD/SUB/FUNCT/XOR/AND.
  - PCSource and ALUSrcB encodings.
- Sub-module mips_ctrl_outputs: purely combinational state-to-outputs decoder. The FSM and wait counter stay in the top module.

Test Plan:
- Reset low for 3 cycles mid-MEM_WR -> MemWrite=0 on the next edge; RST for one cycle after release; FETCH starts the cycle after.
- MEM_WAIT=1, R-type add (Funct 20), Overflow=0 -> FETCH 2 cycles with IRWrite/PCWrite on the 2nd, then DECODE, RTYPE with ALUOp=010, RWB with RegWrite=1 and RegDst=1; 5 cycles total.
- lw (Opcode 23), MEM_WAIT=1 -> MEM_RD holds MemRead=1 and IorD=1 for 2 cycles; MEM_WB has MemtoReg=1 and RegWrite=1; 7 cycles total.
- Branches -> beq with Zero=1 gives PCWrite=1 and PCSource=01; bne with Zero=1 gives PCWrite=0; bne with Zero=0 gives PCWrite=1.
- addi (Opcode 08) with Overflow=1 in ITYPE -> no RegWrite; EXC has EPCWrite=1, CauseWrite=1, Cause=1, ALUOp=001; EXC_VEC has PCSource=11 and PCWrite=1. Opcode 3f gives the same flow with Cause=0.
- Opcode 00 with Break=1 -> HALT; Halted=1 and all strobes 0 for 20 cycles; reset low recovers to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, RTYPE, RWB, ITYPE, IWB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, EXC, EXC_VEC, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_BREAK = 6'h0d;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_XOR   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       cause_write;
    logic       cause;
    logic       halted;
  } ctrl_t;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outputs.sv
// Combinational state-to-control decoder; only BRANCH PCWrite and the ITYPE ALUOp look at inputs.
module mips_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       is_bne_i,
  input  logic       cause_i,
  input  logic       cnt_last_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = cnt_last_i;
        ctrl_o.pc_write  = cnt_last_i;
      end
      DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      RTYPE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      ITYPE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (opcode_i)
          OP_ANDI: ctrl_o.alu_op = ALUOP_AND;
          OP_XORI: ctrl_o.alu_op = ALUOP_XOR;
          default: ctrl_o.alu_op = ALUOP_ADD;
        endcase
      end
      IWB: ctrl_o.reg_write = 1'b1;
      MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      MEM_WR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_write  = zero_i ^ is_bne_i;
      end
      JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
      EXC: begin
        // PC already advanced by 4 in FETCH; subtracting 4 recovers the faulting PC.
        ctrl_o.alu_src_b   = SRCB_FOUR;
        ctrl_o.alu_op      = ALUOP_SUB;
        ctrl_o.epc_write   = 1'b1;
        ctrl_o.cause_write = 1'b1;
        ctrl_o.cause       = cause_i;
      end
      EXC_VEC: begin
        ctrl_o.pc_source = PCSRC_EXC;
        ctrl_o.pc_write  = 1'b1;
      end
      HALT:    ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM with memory wait counter and exception sequencing.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 1,
  parameter int unsigned EXC_CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       Break,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic       Cause,
  output logic       Halted
);

  localparam logic [EXC_CNT_W-1:0] CNT_LAST = EXC_CNT_W'(MEM_WAIT);

  state_t               state_q, state_d;
  logic [EXC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 is_bne_q, is_bne_d;
  logic                 cause_q, cause_d;
  logic                 cnt_last;
  ctrl_t                ctrl;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RST;
      cnt_q    <= '0;
      is_bne_q <= 1'b0;
      cause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_bne_q <= is_bne_d;
      cause_q  <= cause_d;
    end
  end

  // Counter defaults to zero so it clears on every state exit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    is_bne_d = is_bne_q;
    cause_d  = cause_q;
    case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (cnt_last) state_d = DECODE;
        else          cnt_d   = cnt_q + EXC_CNT_W'(1);
      end
      DECODE: begin
        is_bne_d = (Opcode == OP_BNE);
        if (Opcode == OP_RTYPE)                      state_d = Break ? HALT : RTYPE;
        else if (Opcode == OP_LW || Opcode == OP_SW)  state_d = MEM_ADDR;
        else if (Opcode == OP_BEQ || Opcode == OP_BNE) state_d = BRANCH;
        else if (Opcode == OP_J)                     state_d = JUMP;
        else if (is_itype(Opcode))                   state_d = ITYPE;
        else begin
          state_d = EXC;
          cause_d = 1'b0;
        end
      end
      RTYPE: begin
        if (Overflow && (Funct == FN_ADD || Funct == FN_SUB)) begin
          state_d = EXC;
          cause_d = 1'b1;
        end else begin
          state_d = RWB;
        end
      end
      ITYPE: begin
        if (Overflow && Opcode == OP_ADDI) begin
          state_d = EXC;
          cause_d = 1'b1;
        end else begin
          state_d = IWB;
        end
      end
      MEM_ADDR: state_d = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (cnt_last) state_d = MEM_WB;
        else          cnt_d   = cnt_q + EXC_CNT_W'(1);
      end
      MEM_WR: begin
        if (cnt_last) state_d = FETCH;
        else          cnt_d   = cnt_q + EXC_CNT_W'(1);
      end
      RWB, IWB, MEM_WB, BRANCH, JUMP, EXC_VEC: state_d = FETCH;
      EXC:     state_d = EXC_VEC;
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

  mips_ctrl_outputs u_outputs (
    .state_i    (state_q),
    .opcode_i   (Opcode),
    .zero_i     (Zero),
    .is_bne_i   (is_bne_q),
    .cause_i    (cause_q),
    .cnt_last_i (cnt_last),
    .ctrl_o     (ctrl)
  );

  assign ALUOp      = ctrl.alu_op;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign PCSource   = ctrl.pc_source;
  assign PCWrite    = ctrl.pc_write;
  assign EPCWrite   = ctrl.epc_write;
  assign CauseWrite = ctrl.cause_write;
  assign Cause      = ctrl.cause;
  assign Halted     = ctrl.halted;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench: per-instruction expected control sequences compared cycle by cycle.
module tb_mips_main_control;

  localparam int W = 1;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, mrd, mwr, irw, rdst, m2r, rw;
    logic [1:0] pcsrc;
    logic       pcw, epcw, cw, cause, halted;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Opcode = '0, Funct = '0;
  logic       Zero = 1'b0, Overflow = 1'b0, Break = 1'b0;
  logic [2:0] ALUOp;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] ALUSrcB, PCSource;
  logic       PCWrite, EPCWrite, CauseWrite, Cause, Halted;

  ov_t obs;
  ov_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  mips_main_control #(.MEM_WAIT(W), .EXC_CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .Break(Break), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCSource(PCSource), .PCWrite(PCWrite), .EPCWrite(EPCWrite),
    .CauseWrite(CauseWrite), .Cause(Cause), .Halted(Halted)
  );

  always_comb obs = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                     RegDst, MemtoReg, RegWrite, PCSource, PCWrite, EPCWrite,
                     CauseWrite, Cause, Halted};

  task automatic check(input string tag, input ov_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic push_exc(input logic c);
    ov_t s;
    s = '0; s.srcb = 2'b01; s.aluop = 3'b001; s.epcw = 1'b1; s.cw = 1'b1; s.cause = c;
    exp_q.push_back(s);
    s = '0; s.pcsrc = 2'b11; s.pcw = 1'b1;
    exp_q.push_back(s);
  endtask

  // Expected control word for every cycle of one instruction, by instruction class.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    ov_t s;
    exp_q.delete();
    for (int i = 0; i <= W; i++) begin
      s = '0; s.mrd = 1'b1; s.srcb = 2'b01;
      if (i == W) begin s.irw = 1'b1; s.pcw = 1'b1; end
      exp_q.push_back(s);
    end
    s = '0; s.srcb = 2'b11;
    exp_q.push_back(s);
    if (op == 6'h00 && fn == 6'h0d) begin
      s = '0; s.halted = 1'b1;
      exp_q.push_back(s);
    end else if (op == 6'h00) begin
      s = '0; s.srca = 1'b1; s.aluop = 3'b010;
      exp_q.push_back(s);
      if (ov && (fn == 6'h20 || fn == 6'h22)) push_exc(1'b1);
      else begin s = '0; s.rdst = 1'b1; s.rw = 1'b1; exp_q.push_back(s); end
    end else if (op == 6'h23 || op == 6'h2b) begin
      s = '0; s.srca = 1'b1; s.srcb = 2'b10;
      exp_q.push_back(s);
      for (int i = 0; i <= W; i++) begin
        s = '0; s.iord = 1'b1;
        if (op == 6'h23) s.mrd = 1'b1; else s.mwr = 1'b1;
        exp_q.push_back(s);
      end
      if (op == 6'h23) begin s = '0; s.m2r = 1'b1; s.rw = 1'b1; exp_q.push_back(s); end
    end else if (op == 6'h04 || op == 6'h05) begin
      s = '0; s.srca = 1'b1; s.aluop = 3'b001; s.pcsrc = 2'b01;
      s.pcw = (op == 6'h04) ? z : !z;
      exp_q.push_back(s);
    end else if (op == 6'h02) begin
      s = '0; s.pcsrc = 2'b10; s.pcw = 1'b1;
      exp_q.push_back(s);
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h0c || op == 6'h0e) begin
      s = '0; s.srca = 1'b1; s.srcb = 2'b10;
      s.aluop = (op == 6'h0c) ? 3'b100 : (op == 6'h0e) ? 3'b011 : 3'b000;
      exp_q.push_back(s);
      if (ov && op == 6'h08) push_exc(1'b1);
      else begin s = '0; s.rw = 1'b1; exp_q.push_back(s); end
    end else begin
      push_exc(1'b0);
    end
  endtask

  // Entered at a negedge; leaves at the negedge of the RST cycle that follows release.
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("reset_low_%0d", i), '0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_after_release", '0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov, input int abort_at);
    Opcode = op; Funct = fn; Break = (fn == 6'h0d); Zero = z; Overflow = ov;
    build(op, fn, z, ov);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        do_reset(3);
        return;
      end
      @(negedge clk);
      check($sformatf("op%02h_fn%02h_z%0d_v%0d_c%0d", op, fn, z, ov, i), exp_q[i]);
    end
    if (exp_q[exp_q.size()-1].halted) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        check($sformatf("halt_hold_%0d", k), exp_q[exp_q.size()-1]);
      end
      do_reset(2);
    end
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] fns [5];
    ops = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0e, 6'h23, 6'h2b, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h2a, 6'h0d};

    do_reset(2);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 5);
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, -1);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1);
    run_instr(6'h3f, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1, -1);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1, -1);
    run_instr(6'h09, 6'h00, 1'b0, 1'b1, -1);
    run_instr(6'h0c, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h0e, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1);
    run_instr(6'h00, 6'h0d, 1'b0, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 11)];
      run_instr(op, fns[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
